// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS fetch stage: NOP encoding, default
// reset PC, the fetch FSM state enum and the IF/ID payload layout.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    KILL = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc_plus4;
  } ifid_t;

endpackage

// File: rtl/if_fetch_buf.sv
// One-entry holding register for a fetched instruction and its PC+4, used when
// a memory response lands while decode is stalled. Clear beats load beats unload.
module if_fetch_buf
  import mips_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load_i,
  input  logic  unload_i,
  input  logic  clear_i,
  input  ifid_t data_i,
  output logic  full_o,
  output ifid_t data_o
);

  logic  full_q;
  ifid_t data_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
    end else if (clear_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q <= 1'b1;
    end else if (unload_i) begin
      full_q <= 1'b0;
    end
  end

  // NOTE: the payload is deliberately not reset; full_q alone decides whether it is meaningful.
  always_ff @(posedge clk) begin
    if (load_i) begin
      data_q <= data_i;
    end
  end

  assign full_o = full_q;
  assign data_o = data_q;

endmodule

// File: rtl/if_stage.sv
// MIPS instruction-fetch stage: PC, imem request/response handshake and IF/ID register.
// Define IF_BRANCH_DELAY_SLOT_EN to deliver the delay-slot instruction instead of killing it.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCSrcD,
  input  logic [31:0] PCBranchD,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCPlus4D,
  output logic        FetchBusyF
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         pend_valid_q, pend_valid_d;
  logic [31:0]  pend_pc_q, pend_pc_d;
  ifid_t        ifid_q, ifid_d;

  logic         redirect;
  logic         kill_path;
  logic         rsp_good;
  logic [31:0]  pc_seq;
  logic         buf_full, buf_load, buf_unload, buf_clear, buf_free;
  ifid_t        buf_data;

  assign redirect = PCSrcD && !StallD;
  assign pc_seq   = pc_q + 32'd4;

`ifdef IF_BRANCH_DELAY_SLOT_EN
  assign kill_path = 1'b0;
`else
  assign kill_path = redirect;
`endif

  // A response is only usable in REQ; in KILL (or a late one in IDLE) it is dropped.
  assign rsp_good  = (state_q == REQ) && imem_ready && !kill_path;
  assign buf_clear = kill_path;

  if_fetch_buf u_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (buf_load),
    .unload_i (buf_unload),
    .clear_i  (buf_clear),
    .data_i   ('{instr: imem_rdata, pc_plus4: pc_seq}),
    .full_o   (buf_full),
    .data_o   (buf_data)
  );

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d      = state_q;
    pc_d         = pc_q;
    pend_valid_d = pend_valid_q;
    pend_pc_d    = pend_pc_q;
    ifid_d       = ifid_q;
    buf_load     = 1'b0;
    buf_unload   = 1'b0;

    if (StallD) begin
      buf_load = rsp_good;
    end else if (FlushD || kill_path) begin
      ifid_d = '{instr: NOP_INSTR, pc_plus4: 32'd0};
    end else if (buf_full) begin
      ifid_d     = buf_data;
      buf_unload = 1'b1;
    end else if (rsp_good) begin
      ifid_d = '{instr: imem_rdata, pc_plus4: pc_seq};
    end else begin
      ifid_d = '{instr: NOP_INSTR, pc_plus4: 32'd0};
    end

    buf_free = !((buf_full && !buf_clear && !buf_unload) || buf_load);

    unique case (state_q)
      IDLE: begin
        if (redirect) begin
`ifdef IF_BRANCH_DELAY_SLOT_EN
          // A buffered delay slot is delivered now, so the target applies at once.
          if (buf_full) begin
            pc_d         = PCBranchD;
            pend_valid_d = 1'b0;
          end else begin
            pend_valid_d = 1'b1;
            pend_pc_d    = PCBranchD;
          end
`else
          pc_d = PCBranchD;
`endif
        end
        if (!StallF && buf_free) begin
          state_d = REQ;
        end
      end

      REQ: begin
        if (imem_ready) begin
          if (redirect) begin
            pc_d = PCBranchD;
          end else if (pend_valid_q) begin
            pc_d = pend_pc_q;
          end else begin
            pc_d = pc_seq;
          end
          pend_valid_d = 1'b0;
          state_d      = (!StallF && buf_free) ? REQ : IDLE;
        end else if (redirect) begin
          pend_valid_d = 1'b1;
          pend_pc_d    = PCBranchD;
`ifndef IF_BRANCH_DELAY_SLOT_EN
          state_d = KILL;
`endif
        end
      end

      KILL: begin
        if (redirect) begin
          pend_pc_d = PCBranchD;
        end
        if (imem_ready) begin
          pc_d         = redirect ? PCBranchD : pend_pc_q;
          pend_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_valid_q <= 1'b0;
      pend_pc_q    <= 32'd0;
      ifid_q       <= '{instr: NOP_INSTR, pc_plus4: 32'd0};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_valid_q <= pend_valid_d;
      pend_pc_q    <= pend_pc_d;
      ifid_q       <= ifid_d;
    end
  end

  assign imem_req   = (state_q != IDLE);
  assign imem_addr  = pc_q;
  assign FetchBusyF = (state_q != IDLE) && !imem_ready;
  assign InstrD     = ifid_q.instr;
  assign PCPlus4D   = ifid_q.pc_plus4;

endmodule

// File: tb/tb_if_stage.sv
// Directed testbench for if_stage; instruction memory returns addr ^ 32'hC0DE_0000.
// Expectations follow IF_BRANCH_DELAY_SLOT_EN when it is defined for the bench too.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        PCSrcD;
  logic [31:0] PCBranchD;
  logic        StallF;
  logic        StallD;
  logic        FlushD;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] InstrD;
  logic [31:0] PCPlus4D;
  logic        FetchBusyF;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .PCSrcD     (PCSrcD),
    .PCBranchD  (PCBranchD),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ready (imem_ready),
    .imem_rdata (imem_rdata),
    .InstrD     (InstrD),
    .PCPlus4D   (PCPlus4D),
    .FetchBusyF (FetchBusyF)
  );

  assign imem_rdata = imem_addr ^ 32'hC0DE_0000;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Inputs change 1 time unit after the rising edge; checks run 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; PCSrcD = 1'b0; PCBranchD = 32'd0; StallF = 1'b0;
    StallD = 1'b0; FlushD = 1'b0; imem_ready = 1'b0;
    tick(); tick(); settle();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL reset_req: got %b want 0", imem_req); end
    n_cmp++; if (FetchBusyF !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", FetchBusyF); end
    n_cmp++; if (InstrD !== 32'h0000_0000) begin n_bad++; $display("FAIL reset_instr: got %h want 00000000", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0000) begin n_bad++; $display("FAIL reset_pcp4: got %h want 00000000", PCPlus4D); end
  endtask

  task automatic test_stream_and_wait();
    logic [31:0] exp_addr;
    tick(); rst_n = 1'b1; imem_ready = 1'b1; settle();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL first_cycle_req: got %b want 0", imem_req); end
    for (int n = 0; n < 4; n++) begin
      tick(); settle();
      exp_addr = 32'(n) << 2;
      n_cmp++; if (imem_addr !== exp_addr) begin n_bad++; $display("FAIL stream_addr[%0d]: got %h want %h", n, imem_addr, exp_addr); end
      n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL stream_req[%0d]: got %b want 1", n, imem_req); end
      if (n > 0) begin
        n_cmp++; if (InstrD !== ((exp_addr - 32'd4) ^ 32'hC0DE_0000)) begin n_bad++; $display("FAIL stream_instr[%0d]: got %h want %h", n, InstrD, (exp_addr - 32'd4) ^ 32'hC0DE_0000); end
        n_cmp++; if (PCPlus4D !== exp_addr) begin n_bad++; $display("FAIL stream_pcp4[%0d]: got %h want %h", n, PCPlus4D, exp_addr); end
      end
    end
    for (int w = 0; w < 3; w++) begin
      tick(); imem_ready = 1'b0; settle();
      n_cmp++; if (imem_addr !== 32'h0000_0010) begin n_bad++; $display("FAIL wait_addr[%0d]: got %h want 00000010", w, imem_addr); end
      n_cmp++; if (FetchBusyF !== 1'b1) begin n_bad++; $display("FAIL wait_busy[%0d]: got %b want 1", w, FetchBusyF); end
      if (w == 2) begin
        n_cmp++; if (InstrD !== 32'h0000_0000) begin n_bad++; $display("FAIL wait_nop: got %h want 00000000", InstrD); end
      end
    end
    tick(); imem_ready = 1'b1; settle();
    n_cmp++; if (FetchBusyF !== 1'b0) begin n_bad++; $display("FAIL ready_busy: got %b want 0", FetchBusyF); end
    n_cmp++; if (imem_addr !== 32'h0000_0010) begin n_bad++; $display("FAIL ready_addr: got %h want 00000010", imem_addr); end
    tick(); settle();
    n_cmp++; if (InstrD !== 32'hC0DE_0010) begin n_bad++; $display("FAIL waited_instr: got %h want c0de0010", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0014) begin n_bad++; $display("FAIL waited_pcp4: got %h want 00000014", PCPlus4D); end
    n_cmp++; if (imem_addr !== 32'h0000_0014) begin n_bad++; $display("FAIL waited_next_addr: got %h want 00000014", imem_addr); end
  endtask

  task automatic test_redirect_waiting();
    tick(); tick(); tick();
    tick(); imem_ready = 1'b0; PCSrcD = 1'b1; PCBranchD = 32'h0000_0100; settle();
    n_cmp++; if (imem_addr !== 32'h0000_0024) begin n_bad++; $display("FAIL br_addr: got %h want 00000024", imem_addr); end
    n_cmp++; if (InstrD !== 32'hC0DE_0020) begin n_bad++; $display("FAIL br_branch_in_id: got %h want c0de0020", InstrD); end
    tick(); PCSrcD = 1'b0; imem_ready = 1'b1; settle();
    n_cmp++; if (imem_addr !== 32'h0000_0024) begin n_bad++; $display("FAIL br_hold_addr: got %h want 00000024", imem_addr); end
    n_cmp++; if (InstrD !== 32'h0000_0000) begin n_bad++; $display("FAIL br_nop: got %h want 00000000", InstrD); end
`ifdef IF_BRANCH_DELAY_SLOT_EN
    tick(); settle();
    n_cmp++; if (InstrD !== 32'hC0DE_0024) begin n_bad++; $display("FAIL br_delay_slot: got %h want c0de0024", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0028) begin n_bad++; $display("FAIL br_delay_pcp4: got %h want 00000028", PCPlus4D); end
    n_cmp++; if (imem_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL br_target_addr: got %h want 00000100", imem_addr); end
`else
    n_cmp++; if (PCPlus4D !== 32'h0000_0000) begin n_bad++; $display("FAIL br_nop_pcp4: got %h want 00000000", PCPlus4D); end
    tick(); settle();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL br_idle_req: got %b want 0", imem_req); end
    n_cmp++; if (InstrD !== 32'h0000_0000) begin n_bad++; $display("FAIL br_killed: got %h want 00000000", InstrD); end
    tick(); settle();
    n_cmp++; if (imem_addr !== 32'h0000_0100) begin n_bad++; $display("FAIL br_target_addr: got %h want 00000100", imem_addr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL br_target_req: got %b want 1", imem_req); end
`endif
    tick(); settle();
    n_cmp++; if (InstrD !== 32'hC0DE_0100) begin n_bad++; $display("FAIL br_target_instr: got %h want c0de0100", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0104) begin n_bad++; $display("FAIL br_target_pcp4: got %h want 00000104", PCPlus4D); end
    n_cmp++; if (imem_addr !== 32'h0000_0104) begin n_bad++; $display("FAIL br_after_addr: got %h want 00000104", imem_addr); end
  endtask

  task automatic test_redirect_wrap();
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
    tick(); PCSrcD = 1'b0; settle();
    n_cmp++; if (imem_addr !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_target_addr: got %h want fffffffc", imem_addr); end
`ifdef IF_BRANCH_DELAY_SLOT_EN
    n_cmp++; if (InstrD !== 32'hC0DE_0104) begin n_bad++; $display("FAIL wrap_delay_slot: got %h want c0de0104", InstrD); end
`else
    n_cmp++; if (InstrD !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_penalty_nop: got %h want 00000000", InstrD); end
`endif
    tick(); settle();
    n_cmp++; if (InstrD !== 32'h3F21_FFFC) begin n_bad++; $display("FAIL wrap_instr: got %h want 3f21fffc", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_pcp4: got %h want 00000000", PCPlus4D); end
    n_cmp++; if (imem_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_addr); end
  endtask

  task automatic test_stall_buffer();
    tick(); rst_n = 1'b0; PCSrcD = 1'b0; StallD = 1'b0; FlushD = 1'b0; imem_ready = 1'b1; settle();
    tick(); rst_n = 1'b1; settle();
    tick(); settle();
    tick(); settle();
    tick(); StallD = 1'b1; settle();
    n_cmp++; if (imem_addr !== 32'h0000_0008) begin n_bad++; $display("FAIL stall_addr: got %h want 00000008", imem_addr); end
    n_cmp++; if (InstrD !== 32'hC0DE_0004) begin n_bad++; $display("FAIL stall_id_before: got %h want c0de0004", InstrD); end
    tick(); settle();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL stall_buf_req: got %b want 0", imem_req); end
    n_cmp++; if (InstrD !== 32'hC0DE_0004) begin n_bad++; $display("FAIL stall_hold_instr: got %h want c0de0004", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0008) begin n_bad++; $display("FAIL stall_hold_pcp4: got %h want 00000008", PCPlus4D); end
    tick(); StallD = 1'b0; settle();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL release_req: got %b want 0", imem_req); end
    tick(); settle();
    n_cmp++; if (InstrD !== 32'hC0DE_0008) begin n_bad++; $display("FAIL buf_instr: got %h want c0de0008", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_000C) begin n_bad++; $display("FAIL buf_pcp4: got %h want 0000000c", PCPlus4D); end
    n_cmp++; if (imem_addr !== 32'h0000_000C) begin n_bad++; $display("FAIL resume_addr: got %h want 0000000c", imem_addr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL resume_req: got %b want 1", imem_req); end
    tick(); settle();
    n_cmp++; if (InstrD !== 32'hC0DE_000C) begin n_bad++; $display("FAIL resume_instr: got %h want c0de000c", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0010) begin n_bad++; $display("FAIL resume_pcp4: got %h want 00000010", PCPlus4D); end
  endtask

  task automatic test_flush();
    FlushD = 1'b1;
    tick(); FlushD = 1'b0; settle();
    n_cmp++; if (InstrD !== 32'h0000_0000) begin n_bad++; $display("FAIL flush_instr: got %h want 00000000", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0000) begin n_bad++; $display("FAIL flush_pcp4: got %h want 00000000", PCPlus4D); end
    n_cmp++; if (imem_addr !== 32'h0000_0014) begin n_bad++; $display("FAIL flush_pc: got %h want 00000014", imem_addr); end
    tick(); settle();
    n_cmp++; if (InstrD !== 32'hC0DE_0014) begin n_bad++; $display("FAIL post_flush_instr: got %h want c0de0014", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0018) begin n_bad++; $display("FAIL post_flush_pcp4: got %h want 00000018", PCPlus4D); end
  endtask

  task automatic test_reset_mid_request();
    imem_ready = 1'b0; settle();
    n_cmp++; if (FetchBusyF !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", FetchBusyF); end
    n_cmp++; if (imem_addr !== 32'h0000_0018) begin n_bad++; $display("FAIL mid_addr: got %h want 00000018", imem_addr); end
    rst_n = 1'b0;
    tick(); rst_n = 1'b1; imem_ready = 1'b1; settle();
    n_cmp++; if (imem_req !== 1'b0) begin n_bad++; $display("FAIL late_ready_req: got %b want 0", imem_req); end
    n_cmp++; if (FetchBusyF !== 1'b0) begin n_bad++; $display("FAIL late_ready_busy: got %b want 0", FetchBusyF); end
    tick(); imem_ready = 1'b0; settle();
    n_cmp++; if (InstrD !== 32'h0000_0000) begin n_bad++; $display("FAIL late_ready_ignored: got %h want 00000000", InstrD); end
    n_cmp++; if (imem_addr !== 32'h0000_0000) begin n_bad++; $display("FAIL restart_addr: got %h want 00000000", imem_addr); end
    n_cmp++; if (imem_req !== 1'b1) begin n_bad++; $display("FAIL restart_req: got %b want 1", imem_req); end
    imem_ready = 1'b1;
    tick(); settle();
    n_cmp++; if (InstrD !== 32'hC0DE_0000) begin n_bad++; $display("FAIL restart_instr: got %h want c0de0000", InstrD); end
    n_cmp++; if (PCPlus4D !== 32'h0000_0004) begin n_bad++; $display("FAIL restart_pcp4: got %h want 00000004", PCPlus4D); end
  endtask

  initial begin
    test_reset();
    test_stream_and_wait();
    test_redirect_waiting();
    test_redirect_wrap();
    test_stall_buffer();
    test_flush();
    test_reset_mid_request();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
